t_switch_out_sched: RTL and testbench
=====================================

# t_switch_out_sched

Per-output-port scheduler for the T-switch. For one output (l, r or u0) it chooses, each cycle, one (input port, VC) flit among the flits already routed to that output, respecting per-VC credit backpressure from the output's credit counters. Static or fair VC priority is selectable; input selection within a VC is always round-robin. One instance sits between the input FIFOs' DVR outputs and each output's credit counter.

## Interface
- NUM_IN, 2, number of input ports competing for this output (2 in a T-switch)
- A_W, DEFAULT_A_W, address width
- D_W, DEFAULT_D_W, payload width; a flit is A_W+D_W+1 bits
- VC_W, DEFAULT_VC_W, number of virtual channels
- FAIR_VC_ARB, 0, 0 = static lowest-VC-first with starvation guard; 1 = round-robin over VCs
- STARVE_MAX, DEFAULT_STARVE_MAX (15), wait cycles before a VC is promoted (static mode only); ≥1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_v  in  [NUM_IN-1:0][VC_W-1:0]  flit on (input, VC) is valid and routed to this output
- i_d  in  [NUM_IN-1:0][VC_W-1:0][A_W+D_W:0]  flit data per (input, VC)
- i_b  out  [NUM_IN-1:0][VC_W-1:0]  backpressure to inputs; 0 only for the flit accepted this cycle
- o_v  out  [VC_W-1:0]  one-hot VC of the flit sent this cycle, or 0
- o_d  out  [A_W+D_W:0]  sent flit; 0 when o_v is 0
- o_b  in  [VC_W-1:0]  per-VC backpressure from the credit counter (1 = no credit)

## Operation
- Eligible VC v: o_b[v]==0 and any i_v[n][v]==1.
- VC choice, FAIR_VC_ARB=0: if any eligible VC has wait_cnt==STARVE_MAX, the lowest-index such VC wins; otherwise the lowest-index eligible VC wins.
- wait_cnt[v] (static mode): +1 (saturating at STARVE_MAX) when v eligible but not granted; cleared when v granted or not eligible.
- VC choice, FAIR_VC_ARB=1: first eligible VC scanning upward from vc_ptr with wrap; on grant of v, vc_ptr ← (v+1) mod VC_W. wait_cnt unused (held at 0).
- Input choice in granted VC g: first n with i_v[n][g], scanning upward from in_ptr[g] with wrap; on grant of input n, in_ptr[g] ← (n+1) mod NUM_IN. Other VCs' in_ptr unchanged.
- Grant exists iff any VC eligible. Then o_v=onehot(g), o_d=i_d[n][g], i_b[n][g]=0, all other i_b bits 1.
- No grant: o_v=0, o_d=0, i_b all 1; vc_ptr and in_ptr hold.
- rst asserted: o_v=0, o_d=0, i_b all 1 regardless of inputs; vc_ptr, in_ptr, wait_cnt all 0.
- All o_b=1: no grant; wait_cnt cleared (no VC eligible).
- VC_W=1 or NUM_IN=1: pointers are degenerate constant 0; behaviour reduces to pass-through gated by o_b.

## Timing
- Zero-cycle datapath: o_v/o_d/i_b combinational from i_v, i_d, o_b and registered state; no added flit latency.
- All state (vc_ptr, in_ptr[VC_W], wait_cnt[VC_W]) updates on rising clk edge using the current-cycle grant; new priorities apply next cycle.
- Reset release: first grant possible in the same cycle rst deasserts (combinational), with pointers at 0.
- Handshake: a flit transfers from input to output in the cycle where i_v[n][v]=1 and i_b[n][v]=0; the input must hold the flit otherwise.
- At most one flit per cycle on o_v; o_v never set on a VC with o_b=1.

## Structure
- common_pkg: add DEFAULT_STARVE_MAX; wait counter width $clog2(STARVE_MAX+1) computed locally.
- Sub-module rr_pick (parameter W): inputs req[W-1:0], ptr[$clog2(W)-1:0] → one-hot gnt, index, any; rotating first-set-from-ptr. Used once for VC choice (fair mode) and per-VC for input choice.

## Test plan
- NUM_IN=2, VC_W=2, static: both inputs hold VC0 valid continuously, o_b=0 → grants alternate input 0,1,0,1; i_b toggles accordingly.
- Static, STARVE_MAX=3: VC0 and VC1 continuously valid → VC0 granted 3 cycles, wait_cnt[1] hits 3, VC1 granted on 4th, pattern repeats every 4 cycles.
- FAIR_VC_ARB=1, VC_W=2, all valid → o_v alternates 01,10,01,10.
- o_b=2'b01 with VC0 and VC1 valid → VC1 granted every cycle, o_v never 01; o_b=2'b11 → o_v=0, i_b all 1, pointers unchanged on release.
- Assert rst asynchronously mid-traffic → o_v=0 immediately, i_b all 1; after release first grant is input 0 of lowest eligible VC.
- Random i_v/o_b for 10k cycles, scoreboard: each accepted flit appears exactly once on o_d, one-hot o_v, never on a backpressured VC.

Source files
------------

// File: rtl/common_pkg.sv
// Shared defaults and helpers for the T-switch blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package common_pkg;

  localparam int DEFAULT_A_W        = 8;
  localparam int DEFAULT_D_W        = 16;
  localparam int DEFAULT_VC_W       = 2;
  localparam int DEFAULT_STARVE_MAX = 15;

  // Index width that stays at least 1 bit, so W=1 selectors and
  // pointers remain legal (constant-0) vectors.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/t_switch_out_sched_rr_pick.sv
// Rotating first-set picker: first request at or above i_ptr, with wrap.
// Latency: purely combinational.
// Backpressure: none; o_any=0 when no request is set.
// Ports: i_req request vector, i_ptr start index,
//        o_gnt one-hot grant, o_idx grant index, o_any any request.
module rr_pick
  import common_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0]           i_req,
  input  logic [idx_w(W)-1:0]    i_ptr,
  output logic [W-1:0]           o_gnt,
  output logic [idx_w(W)-1:0]    o_idx,
  output logic                   o_any
);

  localparam int PW = idx_w(W);

  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < W; i++) begin
      j = int'(i_ptr) + i;
      if (j >= W) j = j - W;
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/t_switch_out_sched.sv
// Per-output scheduler: picks one (input, VC) flit per cycle honouring per-VC credit.
// Latency: zero-cycle datapath; pointers/wait counters update on clk for next cycle.
// Backpressure: i_b low only for the accepted flit; no grant on a VC with o_b=1.
// Ports: i_v/i_d per (input,VC) flits, i_b per (input,VC) backpressure,
//        o_v one-hot VC sent, o_d sent flit, o_b per-VC no-credit.
module t_switch_out_sched
  import common_pkg::*;
#(
  parameter int NUM_IN      = 2,
  parameter int A_W         = DEFAULT_A_W,
  parameter int D_W         = DEFAULT_D_W,
  parameter int VC_W        = DEFAULT_VC_W,
  parameter int FAIR_VC_ARB = 0,
  parameter int STARVE_MAX  = DEFAULT_STARVE_MAX
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_IN-1:0][VC_W-1:0]            i_v,
  input  logic [NUM_IN-1:0][VC_W-1:0][A_W+D_W:0] i_d,
  output logic [NUM_IN-1:0][VC_W-1:0]            i_b,
  output logic [VC_W-1:0]                        o_v,
  output logic [A_W+D_W:0]                       o_d,
  input  logic [VC_W-1:0]                        o_b
);

  localparam int VPW = idx_w(VC_W);
  localparam int IPW = idx_w(NUM_IN);
  localparam int CW  = $clog2(STARVE_MAX + 1);

  logic [VPW-1:0]                r_vc_ptr;
  logic [VC_W-1:0][IPW-1:0]      r_in_ptr;
  logic [VC_W-1:0][CW-1:0]       r_wait;

  logic [VC_W-1:0][NUM_IN-1:0]   w_col;
  logic [VC_W-1:0][NUM_IN-1:0]   w_in_gnt;
  logic [VC_W-1:0][IPW-1:0]      w_in_idx;
  logic [VC_W-1:0]               w_in_any;
  logic [VC_W-1:0]               w_elig;
  logic [VC_W-1:0]               w_starve;
  logic [VC_W-1:0]               w_vc_req;
  logic [VPW-1:0]                w_vc_start;
  logic [VC_W-1:0]               w_vc_gnt;
  logic [VPW-1:0]                w_vc_idx;
  logic                          w_vc_any;
  logic                          w_grant;

  // Regroup requests by VC so each VC gets its own input picker.
  always_comb begin
    w_col = '0;
    for (int v = 0; v < VC_W; v++)
      for (int n = 0; n < NUM_IN; n++)
        w_col[v][n] = i_v[n][v];
  end

  for (genvar gv = 0; gv < VC_W; gv++) begin : g_in_pick
    rr_pick #(.W(NUM_IN)) u_in_pick (
      .i_req (w_col[gv]),
      .i_ptr (r_in_ptr[gv]),
      .o_gnt (w_in_gnt[gv]),
      .o_idx (w_in_idx[gv]),
      .o_any (w_in_any[gv])
    );
  end

  assign w_elig = ~o_b & w_in_any;

  always_comb begin
    w_starve = '0;
    for (int v = 0; v < VC_W; v++)
      w_starve[v] = w_elig[v] && (r_wait[v] == CW'(STARVE_MAX));
  end

  // Static mode reuses the rotating picker with start index 0, which makes
  // it a lowest-index-first encoder; starving VCs pre-empt the normal set.
  assign w_vc_req   = (FAIR_VC_ARB != 0) ? w_elig :
                      ((|w_starve) ? w_starve : w_elig);
  assign w_vc_start = (FAIR_VC_ARB != 0) ? r_vc_ptr : '0;

  rr_pick #(.W(VC_W)) u_vc_pick (
    .i_req (w_vc_req),
    .i_ptr (w_vc_start),
    .o_gnt (w_vc_gnt),
    .o_idx (w_vc_idx),
    .o_any (w_vc_any)
  );

  // Reset blanks the outputs combinationally, independent of the clock.
  assign w_grant = w_vc_any & ~rst;

  always_comb begin
    o_v = '0;
    o_d = '0;
    i_b = '1;
    if (w_grant) begin
      o_v = w_vc_gnt;
      o_d = i_d[w_in_idx[w_vc_idx]][w_vc_idx];
      for (int v = 0; v < VC_W; v++)
        for (int n = 0; n < NUM_IN; n++)
          if (w_vc_gnt[v] && w_in_gnt[v][n]) i_b[n][v] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vc_ptr <= '0;
      r_in_ptr <= '0;
      r_wait   <= '0;
    end else begin
      if (w_grant) begin
        if (FAIR_VC_ARB != 0)
          r_vc_ptr <= (int'(w_vc_idx) == VC_W - 1) ? '0 : w_vc_idx + VPW'(1);
        r_in_ptr[w_vc_idx] <= (int'(w_in_idx[w_vc_idx]) == NUM_IN - 1) ? '0 :
                              w_in_idx[w_vc_idx] + IPW'(1);
      end
      for (int v = 0; v < VC_W; v++) begin
        if ((FAIR_VC_ARB != 0) || !w_elig[v] || (w_grant && w_vc_gnt[v]))
          r_wait[v] <= '0;
        else if (r_wait[v] != CW'(STARVE_MAX))
          r_wait[v] <= r_wait[v] + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_t_switch_out_sched.sv
module tb_t_switch_out_sched;

  localparam int FW = 8;  // A_W=4, D_W=3 -> 8-bit flit

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][1:0]         iv_s, iv_f, ib_s, ib_f;
  logic [1:0][1:0][FW-1:0] id_s, id_f;
  logic [1:0]              ob_s, ob_f, ov_s, ov_f;
  logic [FW-1:0]           od_s, od_f;

  t_switch_out_sched #(.NUM_IN(2), .A_W(4), .D_W(3), .VC_W(2),
                       .FAIR_VC_ARB(0), .STARVE_MAX(3)) dut_s (
    .clk(clk), .rst(rst), .i_v(iv_s), .i_d(id_s), .i_b(ib_s),
    .o_v(ov_s), .o_d(od_s), .o_b(ob_s));

  t_switch_out_sched #(.NUM_IN(2), .A_W(4), .D_W(3), .VC_W(2),
                       .FAIR_VC_ARB(1), .STARVE_MAX(3)) dut_f (
    .clk(clk), .rst(rst), .i_v(iv_f), .i_d(id_f), .i_b(ib_f),
    .o_v(ov_f), .o_d(od_f), .o_b(ob_f));

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] dval(input int n, input int v);
    logic [7:0] r;
    r = 8'(8'h10 * (n + 1) + v + 5);
    return r;
  endfunction

  function automatic logic [3:0] exp_ib(input logic [1:0] vc, input int n);
    logic [3:0] r;
    r = 4'hF;
    if (vc != 2'b00) r[n*2 + (vc[1] ? 1 : 0)] = 1'b0;
    return r;
  endfunction

  function automatic logic [FW-1:0] exp_od(input logic [1:0] vc, input int n);
    if (vc == 2'b00) return '0;
    return dval(n, vc[1] ? 1 : 0);
  endfunction

  task automatic drive(input bit f, input logic [3:0] iv, input logic [1:0] ob,
                       input logic [1:0][1:0][FW-1:0] d);
    if (f) begin iv_f = iv; ob_f = ob; id_f = d; end
    else   begin iv_s = iv; ob_s = ob; id_s = d; end
  endtask

  // iv bits: {n1v1, n1v0, n0v1, n0v0}
  typedef struct {
    logic [3:0] iv;
    logic [1:0] ob;
    logic [1:0] sv;
    int         sn;
    logic [1:0] fv;
    int         fn;
  } vec_t;

  vec_t tbl[18];
  logic [1:0][1:0][FW-1:0] dfix;

  task automatic rand_run(input bit f, input int ncyc);
    bit vld[4];
    bit acc[4];
    logic [5:0] seq[4];
    logic [1:0][1:0][FW-1:0] d;
    logic [3:0] iv, ib;
    logic [1:0] ob, ov;
    logic [FW-1:0] od;
    bit ok, any;
    int vi, zeros, zpos;
    for (int s = 0; s < 4; s++) begin vld[s] = 0; acc[s] = 0; seq[s] = '0; end
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      for (int s = 0; s < 4; s++) begin
        if (acc[s]) begin seq[s] = seq[s] + 6'd1; vld[s] = 0; acc[s] = 0; end
        if (!vld[s]) vld[s] = ($urandom_range(0, 1) == 1);
      end
      ob[0] = ($urandom_range(0, 3) == 0);
      ob[1] = ($urandom_range(0, 3) == 0);
      for (int s = 0; s < 4; s++) begin
        iv[s] = vld[s];
        d[s/2][s%2] = {1'(s/2), 1'(s%2), seq[s]};
      end
      drive(f, iv, ob, d);
      @(negedge clk);
      if (f) begin ov = ov_f; ib = ib_f; od = od_f; end
      else   begin ov = ov_s; ib = ib_s; od = od_s; end
      any = 0;
      for (int s = 0; s < 4; s++) if (vld[s] && !ob[s%2]) any = 1;
      zeros = 0; zpos = 0;
      for (int s = 0; s < 4; s++) if (!ib[s]) begin zeros++; zpos = s; end
      if (ov == 2'b00) begin
        ok = !any && (ib == 4'hF) && (od == '0);
      end else begin
        vi = ov[1] ? 1 : 0;
        ok = (ov == 2'b01 || ov == 2'b10) && !ob[vi] && any && (zeros == 1) &&
             (zpos % 2 == vi) && vld[zpos] &&
             (od == {1'(zpos/2), 1'(zpos%2), seq[zpos]});
        if (ok) acc[zpos] = 1;
      end
      checks++;
      if (!ok) begin
        errs++;
        $display("FAIL rand%0d cyc %0d: o_v=%b o_d=%h i_b=%b with i_v=%b o_b=%b", f, c, ov, od, ib, iv, ob);
      end
    end
    @(posedge clk); #1;
    drive(f, 4'b0000, 2'b00, d);
  endtask

  initial begin
    for (int n = 0; n < 2; n++)
      for (int v = 0; v < 2; v++)
        dfix[n][v] = dval(n, v);

    tbl[0]  = '{4'b0101, 2'b00, 2'b01, 0, 2'b01, 0};
    tbl[1]  = '{4'b0101, 2'b00, 2'b01, 1, 2'b01, 1};
    tbl[2]  = '{4'b0101, 2'b00, 2'b01, 0, 2'b01, 0};
    tbl[3]  = '{4'b0101, 2'b00, 2'b01, 1, 2'b01, 1};
    tbl[4]  = '{4'b1111, 2'b00, 2'b01, 0, 2'b10, 0};
    tbl[5]  = '{4'b1111, 2'b00, 2'b01, 1, 2'b01, 0};
    tbl[6]  = '{4'b1111, 2'b00, 2'b01, 0, 2'b10, 1};
    tbl[7]  = '{4'b1111, 2'b00, 2'b10, 0, 2'b01, 1};
    tbl[8]  = '{4'b1111, 2'b00, 2'b01, 1, 2'b10, 0};
    tbl[9]  = '{4'b1111, 2'b01, 2'b10, 1, 2'b10, 1};
    tbl[10] = '{4'b1111, 2'b01, 2'b10, 0, 2'b10, 0};
    tbl[11] = '{4'b1111, 2'b11, 2'b00, 0, 2'b00, 0};
    tbl[12] = '{4'b1111, 2'b11, 2'b00, 0, 2'b00, 0};
    tbl[13] = '{4'b1111, 2'b00, 2'b01, 0, 2'b01, 0};
    tbl[14] = '{4'b1000, 2'b00, 2'b10, 1, 2'b10, 1};
    tbl[15] = '{4'b0000, 2'b00, 2'b00, 0, 2'b00, 0};
    tbl[16] = '{4'b0100, 2'b10, 2'b01, 1, 2'b01, 1};
    tbl[17] = '{4'b0010, 2'b10, 2'b00, 0, 2'b00, 0};

    // Reset with traffic present: outputs must stay idle.
    rst = 1'b1;
    drive(0, 4'b1111, 2'b00, dfix);
    drive(1, 4'b1111, 2'b00, dfix);
    @(negedge clk);
    chk("rst_ov_s", 32'(ov_s), 32'h0);
    chk("rst_ov_f", 32'(ov_f), 32'h0);
    chk("rst_ib_s", 32'(ib_s), 32'hF);
    chk("rst_ib_f", 32'(ib_f), 32'hF);
    chk("rst_od_s", 32'(od_s), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(0, tbl[i].iv, tbl[i].ob, dfix);
      drive(1, tbl[i].iv, tbl[i].ob, dfix);
      @(negedge clk);
      chk($sformatf("t%0d_ov_s", i), 32'(ov_s), 32'(tbl[i].sv));
      chk($sformatf("t%0d_ib_s", i), 32'(ib_s), 32'(exp_ib(tbl[i].sv, tbl[i].sn)));
      chk($sformatf("t%0d_od_s", i), 32'(od_s), 32'(exp_od(tbl[i].sv, tbl[i].sn)));
      chk($sformatf("t%0d_ov_f", i), 32'(ov_f), 32'(tbl[i].fv));
      chk($sformatf("t%0d_ib_f", i), 32'(ib_f), 32'(exp_ib(tbl[i].fv, tbl[i].fn)));
      chk($sformatf("t%0d_od_f", i), 32'(od_f), 32'(exp_od(tbl[i].fv, tbl[i].fn)));
      @(posedge clk); #1;
    end

    // Asynchronous reset mid-cycle with traffic flowing.
    drive(0, 4'b1111, 2'b00, dfix);
    drive(1, 4'b1111, 2'b00, dfix);
    #2 rst = 1'b1;
    #1;
    chk("arst_ov_s", 32'(ov_s), 32'h0);
    chk("arst_ov_f", 32'(ov_f), 32'h0);
    chk("arst_ib_s", 32'(ib_s), 32'hF);
    chk("arst_ib_f", 32'(ib_f), 32'hF);
    chk("arst_od_f", 32'(od_f), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ov_s", 32'(ov_s), 32'h1);
    chk("rel_ib_s", 32'(ib_s), 32'(exp_ib(2'b01, 0)));
    chk("rel_od_s", 32'(od_s), 32'(dval(0, 0)));
    chk("rel_ov_f", 32'(ov_f), 32'h1);
    chk("rel_ib_f", 32'(ib_f), 32'(exp_ib(2'b01, 0)));

    rand_run(0, 5000);
    rand_run(1, 5000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
